// File: rtl/fixed_tanhshrink_pipe.sv
// Two-stage tanhshrink / tanh pipeline over N signed fixed-point lanes with valid/ready flow.
// Optional macro FIXED_TANHSHRINK_ROUND_EN: round-to-nearest when reducing input fraction bits.
module fixed_tanhshrink_pipe #(
   parameter int DATA_IN_0_PRECISION_0       = 8,
   parameter int DATA_IN_0_PRECISION_1       = 4,
   parameter int DATA_OUT_0_PRECISION_0      = 8,
   parameter int DATA_OUT_0_PRECISION_1      = 4,
   parameter int DATA_IN_0_PARALLELISM_DIM_0 = 1,
   parameter int DATA_IN_0_PARALLELISM_DIM_1 = 1,
   parameter int MODE                        = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_IN_0_PRECISION_0-1:0] data_in_0,
   input  logic data_in_0_valid,
   output logic data_in_0_ready,
   output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PARALLELISM_DIM_1*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
   output logic data_out_0_valid,
   input  logic data_out_0_ready
);

   localparam int W  = DATA_IN_0_PRECISION_0;
   localparam int FI = DATA_IN_0_PRECISION_1;
   localparam int OW = DATA_OUT_0_PRECISION_0;
   localparam int FO = DATA_OUT_0_PRECISION_1;
   localparam int N  = DATA_IN_0_PARALLELISM_DIM_0 * DATA_IN_0_PARALLELISM_DIM_1;
   localparam int AW = W + FO + 2;
   localparam int LW = FO + 2;
   localparam int DW = AW + 1;

   localparam logic signed [DW-1:0] SAT_MAX = (DW'(1) <<< (OW - 1)) - DW'(1);
   localparam logic signed [DW-1:0] SAT_MIN = ~SAT_MAX;

   // Elaboration-time only: tanh of the raw word, rounded half away from zero.
   function automatic int tanh_entry(input int unsigned idx);
      int  xi;
      real xr;
      real tr;
      xi = (idx >= (1 << (W - 1))) ? int'(idx) - (1 << W) : int'(idx);
      xr = real'(xi) / (2.0 ** FI);
      tr = $tanh(xr) * (2.0 ** FO);
      if (tr >= 0.0) return int'($floor(tr + 0.5));
      else           return -int'($floor(-tr + 0.5));
   endfunction

   logic signed [LW-1:0] tanh_lut [1 << W];

   for (genvar gi = 0; gi < (1 << W); gi++) begin : g_lut
      localparam int ENTRY = tanh_entry(gi);
      assign tanh_lut[gi] = LW'(ENTRY);
   end

   logic                 s1_valid;
   logic                 s2_valid;
   logic                 s1_adv;
   logic                 s2_adv;
   logic signed [AW-1:0] s1_x [N];
   logic signed [LW-1:0] s1_t [N];
   logic signed [AW-1:0] x_al [N];
   logic signed [LW-1:0] t_in [N];
   logic [N*OW-1:0]      res_sat;
   logic [N*OW-1:0]      s2_data;

   assign s2_adv          = !s2_valid || data_out_0_ready;
   assign s1_adv          = !s1_valid || s2_adv;
   assign data_in_0_ready = s1_adv;

   for (genvar gl = 0; gl < N; gl++) begin : g_lane
      logic signed [W-1:0]  x_raw;
      logic signed [AW-1:0] x_ext;
      logic signed [DW-1:0] res;
      logic [OW-1:0]        sat_word;

      assign x_raw    = data_in_0[gl*W +: W];
      assign x_ext    = AW'(x_raw);
      assign t_in[gl] = tanh_lut[data_in_0[gl*W +: W]];

      if (FO >= FI) begin : g_up
         assign x_al[gl] = x_ext <<< (FO - FI);
      end else begin : g_down
         localparam int SH = FI - FO;
`ifdef FIXED_TANHSHRINK_ROUND_EN
         localparam logic signed [AW-1:0] HALF = AW'(1) <<< (SH - 1);
         assign x_al[gl] = (x_ext + HALF) >>> SH;
`else
         assign x_al[gl] = x_ext >>> SH;
`endif
      end

      assign res = (MODE == 0) ? (DW'(s1_x[gl]) - DW'(s1_t[gl])) : DW'(s1_t[gl]);

      always_comb begin
         sat_word = OW'(res);
         if (res > SAT_MAX)      sat_word = OW'(SAT_MAX);
         else if (res < SAT_MIN) sat_word = OW'(SAT_MIN);
      end

      assign res_sat[gl*OW +: OW] = sat_word;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s1_valid <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= data_in_0_valid;
         if (data_in_0_valid) begin
            for (int unsigned i = 0; i < N; i++) begin
               s1_x[i] <= x_al[i];
               s1_t[i] <= t_in[i];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         s2_valid <= 1'b0;
         s2_data  <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) s2_data <= res_sat;
      end
   end

   assign data_out_0       = s2_data;
   assign data_out_0_valid = s2_valid;

endmodule

// File: tb/tb_fixed_tanhshrink_pipe.sv
// Directed bench for fixed_tanhshrink_pipe: defaults, saturation, fraction reduction,
// backpressure streaming, mid-stream reset and a 4-lane tanh configuration.
module tb_fixed_tanhshrink_pipe;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [7:0] din        = '0;
   logic       din_valid  = 1'b0;
   logic       out_ready  = 1'b1;

   logic       rdy_m, vout_m;
   logic [7:0] dout_m;
   logic       rdy_s, vout_s;
   logic [5:0] dout_s;
   logic       rdy_r, vout_r;
   logic [7:0] dout_r;

   logic [31:0] din4       = '0;
   logic        din4_valid = 1'b0;
   logic        rdy_l, vout_l;
   logic [31:0] dout_l;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   fixed_tanhshrink_pipe u_dut (
      .clk(clk), .rst(rst),
      .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_m),
      .data_out_0(dout_m), .data_out_0_valid(vout_m), .data_out_0_ready(out_ready)
   );

   fixed_tanhshrink_pipe #(.DATA_OUT_0_PRECISION_0(6)) u_sat (
      .clk(clk), .rst(rst),
      .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_s),
      .data_out_0(dout_s), .data_out_0_valid(vout_s), .data_out_0_ready(out_ready)
   );

   fixed_tanhshrink_pipe #(.DATA_OUT_0_PRECISION_1(2)) u_fo2 (
      .clk(clk), .rst(rst),
      .data_in_0(din), .data_in_0_valid(din_valid), .data_in_0_ready(rdy_r),
      .data_out_0(dout_r), .data_out_0_valid(vout_r), .data_out_0_ready(out_ready)
   );

   fixed_tanhshrink_pipe #(.MODE(1), .DATA_IN_0_PARALLELISM_DIM_0(4)) u_lanes (
      .clk(clk), .rst(rst),
      .data_in_0(din4), .data_in_0_valid(din4_valid), .data_in_0_ready(rdy_l),
      .data_out_0(dout_l), .data_out_0_valid(vout_l), .data_out_0_ready(out_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      tick();
      tick();
      tests_run++;
      if (vout_m !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_valid: got %b want 0", vout_m);
      end
      tests_run++;
      if (dout_m !== 8'h00) begin
         tests_failed++;
         $display("FAIL reset_data: got %h want 00", dout_m);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (rdy_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_ready: got %b want 1", rdy_m);
      end
   endtask

   task automatic test_basic();
      logic [7:0] vin  [3] = '{8'h10, 8'h7F, 8'h80};
      logic [7:0] vexp [3] = '{8'h04, 8'h6F, 8'h90};
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         din_valid = (c < 3);
         din       = (c < 3) ? vin[c] : 8'h00;
         tick();
         tests_run++;
         if (vout_m !== (c >= 1 && c <= 3)) begin
            tests_failed++;
            $display("FAIL basic_valid c=%0d: got %b want %b", c, vout_m, (c >= 1 && c <= 3));
         end
         if (c >= 1 && c <= 3) begin
            tests_run++;
            if (dout_m !== vexp[c-1]) begin
               tests_failed++;
               $display("FAIL basic_data c=%0d: got %h want %h", c, dout_m, vexp[c-1]);
            end
         end
      end
   endtask

   task automatic test_saturate();
      logic [7:0] vin  [2] = '{8'h7F, 8'h80};
      logic [5:0] vexp [2] = '{6'h1F, 6'h20};
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         din_valid = (c < 2);
         din       = (c < 2) ? vin[c] : 8'h00;
         tick();
         if (c >= 1 && c <= 2) begin
            tests_run++;
            if (vout_s !== 1'b1 || dout_s !== vexp[c-1]) begin
               tests_failed++;
               $display("FAIL saturate c=%0d: got v=%b d=%h want v=1 d=%h", c, vout_s, dout_s, vexp[c-1]);
            end
         end
      end
   endtask

   task automatic test_round();
      logic [7:0] vin  [3] = '{8'h13, 8'h10, 8'hED};
`ifdef FIXED_TANHSHRINK_ROUND_EN
      logic [7:0] vexp [3] = '{8'h02, 8'h01, 8'hFE};
`else
      logic [7:0] vexp [3] = '{8'h01, 8'h01, 8'hFE};
`endif
      out_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         din_valid = (c < 3);
         din       = (c < 3) ? vin[c] : 8'h00;
         tick();
         if (c >= 1 && c <= 3) begin
            tests_run++;
            if (vout_r !== 1'b1 || dout_r !== vexp[c-1]) begin
               tests_failed++;
               $display("FAIL round c=%0d: got v=%b d=%h want v=1 d=%h", c, vout_r, dout_r, vexp[c-1]);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vexp [32] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1,
                                8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd3, 8'd3, 8'd4,
                                8'd4, 8'd5, 8'd6, 8'd6, 8'd7, 8'd8, 8'd9, 8'd10,
                                8'd10, 8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17};
      int         sent = 0;
      int         recv = 0;
      int         cyc  = 0;
      logic       held = 1'b0;
      logic [7:0] held_data = '0;
      logic       in_fire;
      while (recv < 32 && cyc < 400) begin
         if (held) begin
            tests_run++;
            if (vout_m !== 1'b1 || dout_m !== held_data) begin
               tests_failed++;
               $display("FAIL stall_hold: got v=%b d=%h want v=1 d=%h", vout_m, dout_m, held_data);
            end
         end
         out_ready = 1'($urandom_range(0, 1));
         din_valid = (sent < 32);
         din       = (sent < 32) ? 8'(sent + 1) : 8'h00;
         #1;
         in_fire = din_valid && rdy_m;
         held    = 1'b0;
         if (vout_m) begin
            if (out_ready) begin
               tests_run++;
               if (dout_m !== vexp[recv]) begin
                  tests_failed++;
                  $display("FAIL stream idx=%0d: got %h want %h", recv, dout_m, vexp[recv]);
               end
               recv++;
            end else begin
               held      = 1'b1;
               held_data = dout_m;
            end
         end
         tick();
         if (in_fire) sent++;
         cyc++;
      end
      tests_run++;
      if (recv != 32) begin
         tests_failed++;
         $display("FAIL stream_count: got %0d want 32", recv);
      end
      din_valid = 1'b0;
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (vout_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL stream_extra c=%0d: got v=%b want 0", c, vout_m);
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b1;
      din_valid = 1'b1;
      din       = 8'h10;
      tick();
      din       = 8'h20;
      tick();
      din_valid = 1'b0;
      din       = 8'h00;
      rst       = 1'b0;
      tick();
      tests_run++;
      if (vout_m !== 1'b0 || dout_m !== 8'h00) begin
         tests_failed++;
         $display("FAIL midreset_clear: got v=%b d=%h want v=0 d=00", vout_m, dout_m);
      end
      rst = 1'b1;
      #1;
      tests_run++;
      if (rdy_m !== 1'b1) begin
         tests_failed++;
         $display("FAIL midreset_ready: got %b want 1", rdy_m);
      end
      for (int c = 0; c < 4; c++) begin
         tick();
         tests_run++;
         if (vout_m !== 1'b0) begin
            tests_failed++;
            $display("FAIL midreset_stale c=%0d: got v=%b want 0", c, vout_m);
         end
      end
   endtask

   task automatic test_lanes();
      logic [31:0] vin  [2] = '{{8'h7F, 8'hF0, 8'h00, 8'h10}, {8'h80, 8'h80, 8'h80, 8'h80}};
      logic [31:0] vexp [2] = '{{8'h10, 8'hF4, 8'h00, 8'h0C}, {8'hF0, 8'hF0, 8'hF0, 8'hF0}};
      out_ready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         din4_valid = (c < 2);
         din4       = (c < 2) ? vin[c] : 32'h0;
         tick();
         if (c >= 1 && c <= 2) begin
            tests_run++;
            if (vout_l !== 1'b1 || dout_l !== vexp[c-1]) begin
               tests_failed++;
               $display("FAIL lanes c=%0d: got v=%b d=%h want v=1 d=%h", c, vout_l, dout_l, vexp[c-1]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_saturate();
      test_round();
      test_back_to_back();
      test_reset_midstream();
      test_lanes();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
